secded_stream_decoder: RTL and testbench

//  Receive-side counterpart to the XOR parity/encode networks in this design.

---
 rtl/secded_stream_decoder.sv | 187 ++++++++++++++++++
 tb/tb_secded_stream_decoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/secded_stream_decoder.sv
// (39,32) Hamming SEC-DED stream decoder: two-stage valid/ready pipeline that
// corrects single-bit errors, flags double-bit errors and counts both.
module secded_stream_decoder #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [6:0]        in_chk,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_corr,
    output logic              out_uncorr,
    output logic [5:0]        out_syndrome,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    localparam int unsigned NPOS = 38;

    // Received codeword by Hamming position; index 0 holds the overall parity bit.
    logic [NPOS:0] in_cw;
    logic [NPOS:1] syn_term [6];
    logic [5:0]    in_syn;
    logic          in_par;

    assign in_cw[0] = in_chk[6];

    for (genvar p = 1; p <= NPOS; p++) begin : g_pos
        if ((p & (p - 1)) == 0) begin : g_chk
            assign in_cw[p] = in_chk[$clog2(p)];
        end else begin : g_data
            assign in_cw[p] = in_data[p - 1 - $clog2(p)];
        end
        for (genvar i = 0; i < 6; i++) begin : g_syn
            if (((p >> i) & 1) == 1) begin : g_on
                assign syn_term[i][p] = in_cw[p];
            end else begin : g_off
                assign syn_term[i][p] = 1'b0;
            end
        end
    end

    for (genvar i = 0; i < 6; i++) begin : g_syn_red
        assign in_syn[i] = ^syn_term[i];
    end

    assign in_par = ^in_cw;

    // Stage 1: raw codeword plus syndrome and overall parity
    logic              s1_full_q, s1_full_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic [5:0]        s1_syn_q, s1_syn_d;
    logic              s1_par_q, s1_par_d;

    // Stage 2: output registers
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_corr_q, out_corr_d;
    logic              out_uncorr_q, out_uncorr_d;
    logic [5:0]        out_syn_q, out_syn_d;

    logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

    logic              s2_free;
    logic              s1_load;
    logic              out_fire;

    assign s2_free  = !out_valid_q || out_ready;
    assign in_ready = !rst && (!s1_full_q || s2_free);
    assign s1_load  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    // One-hot data flip mask: bit k set when the syndrome names data bit k's position.
    logic [DATA_W-1:0] flip_mask;
    for (genvar p = 1; p <= NPOS; p++) begin : g_flip
        if ((p & (p - 1)) != 0) begin : g_data
            assign flip_mask[p - 1 - $clog2(p)] = (s1_syn_q == 6'(p));
        end
    end

    logic s1_correctable;
    logic s1_uncorrectable;

    always_comb begin
        s1_correctable   = 1'b0;
        s1_uncorrectable = 1'b0;
        if (s1_par_q) begin
            if (s1_syn_q <= 6'(NPOS)) begin
                s1_correctable = 1'b1;
            end else begin
                s1_uncorrectable = 1'b1;
            end
        end else if (s1_syn_q != 6'd0) begin
            s1_uncorrectable = 1'b1;
        end
    end

    always_comb begin
        s1_full_d = s1_load || (s1_full_q && !s2_free);
        s1_data_d = s1_data_q;
        s1_syn_d  = s1_syn_q;
        s1_par_d  = s1_par_q;
        if (s1_load) begin
            s1_data_d = in_data;
            s1_syn_d  = in_syn;
            s1_par_d  = in_par;
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_corr_d   = out_corr_q;
        out_uncorr_d = out_uncorr_q;
        out_syn_d    = out_syn_q;
        if (s2_free) begin
            out_valid_d = s1_full_q;
            if (s1_full_q) begin
                out_data_d   = s1_correctable ? (s1_data_q ^ flip_mask) : s1_data_q;
                out_corr_d   = s1_correctable;
                out_uncorr_d = s1_uncorrectable;
                out_syn_d    = s1_syn_q;
            end
        end
    end

    // Clear wins over a same-cycle event; counts stick at all-ones.
    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (cnt_clr) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (out_fire) begin
            if (out_corr_q && (corr_cnt_q != '1)) begin
                corr_cnt_d = corr_cnt_q + 1'b1;
            end
            if (out_uncorr_q && (uncorr_cnt_q != '1)) begin
                uncorr_cnt_d = uncorr_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_full_q    <= 1'b0;
            s1_data_q    <= '0;
            s1_syn_q     <= '0;
            s1_par_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_corr_q   <= 1'b0;
            out_uncorr_q <= 1'b0;
            out_syn_q    <= '0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            s1_full_q    <= s1_full_d;
            s1_data_q    <= s1_data_d;
            s1_syn_q     <= s1_syn_d;
            s1_par_q     <= s1_par_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_corr_q   <= out_corr_d;
            out_uncorr_q <= out_uncorr_d;
            out_syn_q    <= out_syn_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_corr     = out_corr_q;
    assign out_uncorr   = out_uncorr_q;
    assign out_syndrome = out_syn_q;
    assign corr_cnt     = corr_cnt_q;
    assign uncorr_cnt   = uncorr_cnt_q;

endmodule

// File: tb/tb_secded_stream_decoder.sv
// Directed bench for secded_stream_decoder: a 16-bit-counter instance and a 2-bit-counter
// instance share one stimulus stream.
module tb_secded_stream_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic [6:0]  in_chk;
    logic        out_ready;
    logic        cnt_clr;

    logic        in_ready, out_valid, out_corr, out_uncorr;
    logic [31:0] out_data;
    logic [5:0]  out_syndrome;
    logic [15:0] corr_cnt, uncorr_cnt;

    logic        n_in_ready, n_out_valid, n_out_corr, n_out_uncorr;
    logic [31:0] n_out_data;
    logic [5:0]  n_out_syndrome;
    logic [1:0]  n_corr_cnt, n_uncorr_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    secded_stream_decoder #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_chk(in_chk), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_corr(out_corr), .out_uncorr(out_uncorr),
        .out_syndrome(out_syndrome), .cnt_clr(cnt_clr), .corr_cnt(corr_cnt),
        .uncorr_cnt(uncorr_cnt)
    );

    secded_stream_decoder #(.DATA_W(32), .CNT_W(2)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_data(in_data), .in_chk(in_chk), .out_valid(n_out_valid), .out_ready(out_ready),
        .out_data(n_out_data), .out_corr(n_out_corr), .out_uncorr(n_out_uncorr),
        .out_syndrome(n_out_syndrome), .cnt_clr(cnt_clr), .corr_cnt(n_corr_cnt),
        .uncorr_cnt(n_uncorr_cnt)
    );

    typedef struct {
        logic [31:0] data;
        logic [6:0]  chk;
        logic [31:0] exp_data;
        logic        exp_corr;
        logic        exp_uncorr;
        logic [5:0]  exp_syn;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] stream_word(input int k);
        return 32'h1 | (32'h1 << (k + 1));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_corr_cnt;
        int exp_uncorr_cnt;
        int sent;
        int rcvd;
        logic        hold_prev;
        logic        saw_stall;
        logic [31:0] prev_data;
        logic [5:0]  prev_syn;

        //            data          chk     exp_data      corr  uncorr syn
        vecs[0]  = '{32'h0000_0000, 7'h00, 32'h0000_0000, 1'b0, 1'b0, 6'd0};
        vecs[1]  = '{32'h0000_0001, 7'h00, 32'h0000_0000, 1'b1, 1'b0, 6'd3};
        vecs[2]  = '{32'h0000_0003, 7'h00, 32'h0000_0003, 1'b0, 1'b1, 6'd6};
        vecs[3]  = '{32'h0000_0000, 7'h40, 32'h0000_0000, 1'b1, 1'b0, 6'd0};
        vecs[4]  = '{32'h0000_0001, 7'h43, 32'h0000_0001, 1'b0, 1'b0, 6'd0};
        vecs[5]  = '{32'h0000_0003, 7'h43, 32'h0000_0001, 1'b1, 1'b0, 6'd5};
        vecs[6]  = '{32'h8000_0000, 7'h26, 32'h8000_0000, 1'b0, 1'b0, 6'd0};
        vecs[7]  = '{32'h8000_0000, 7'h2E, 32'h8000_0000, 1'b1, 1'b0, 6'd8};
        vecs[8]  = '{32'h0000_0001, 7'h24, 32'h0000_0001, 1'b0, 1'b1, 6'd39};
        vecs[9]  = '{32'h8000_0000, 7'h00, 32'h0000_0000, 1'b1, 1'b0, 6'd38};
        vecs[10] = '{32'h0000_0010, 7'h00, 32'h0000_0000, 1'b1, 1'b0, 6'd9};
        vecs[11] = '{32'h0000_0000, 7'h01, 32'h0000_0000, 1'b1, 1'b0, 6'd1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_chk    = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;

        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_out_data", out_data, 0);
        check("post_rst_flags", {out_corr, out_uncorr}, 0);
        check("post_rst_syndrome", out_syndrome, 0);
        check("post_rst_counters", {corr_cnt, uncorr_cnt}, 0);

        exp_corr_cnt   = 0;
        exp_uncorr_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[i].data;
            in_chk   = vecs[i].chk;
            tick();
            in_valid = 1'b0;
            check($sformatf("v%0d_latency", i), out_valid, 0);
            tick();
            check($sformatf("v%0d_valid", i), out_valid, 1);
            check($sformatf("v%0d_data", i), out_data, vecs[i].exp_data);
            check($sformatf("v%0d_corr", i), out_corr, vecs[i].exp_corr);
            check($sformatf("v%0d_uncorr", i), out_uncorr, vecs[i].exp_uncorr);
            check($sformatf("v%0d_syn", i), out_syndrome, vecs[i].exp_syn);
            exp_corr_cnt   += int'(vecs[i].exp_corr);
            exp_uncorr_cnt += int'(vecs[i].exp_uncorr);
            tick();
            check($sformatf("v%0d_corr_cnt", i), corr_cnt, exp_corr_cnt);
            check($sformatf("v%0d_uncorr_cnt", i), uncorr_cnt, exp_uncorr_cnt);
            check($sformatf("v%0d_drained", i), out_valid, 0);
        end

        // Back-to-back stream with out_ready low for cycles 3..6
        sent      = 0;
        rcvd      = 0;
        hold_prev = 1'b0;
        saw_stall = 1'b0;
        prev_data = '0;
        prev_syn  = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            in_valid  = (sent < 8);
            in_data   = stream_word(sent);
            in_chk    = 7'h00;
            out_ready = !(cyc >= 3 && cyc <= 6);
            @(negedge clk);
            if (!in_ready) saw_stall = 1'b1;
            if (hold_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_syn", out_syndrome, prev_syn);
            end
            if (out_valid && out_ready) begin
                if (rcvd < 8) begin
                    check($sformatf("stream_data%0d", rcvd), out_data, stream_word(rcvd));
                    check($sformatf("stream_uncorr%0d", rcvd), out_uncorr, 1);
                end else begin
                    check("stream_extra_word", rcvd, 8);
                end
                rcvd++;
            end
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;
            prev_syn  = out_syndrome;
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_sent", sent, 8);
        check("stream_rcvd", rcvd, 8);
        check("stream_backpressure", saw_stall, 1);
        check("stream_uncorr_cnt", uncorr_cnt, exp_uncorr_cnt + 8);

        // Narrow counters: clear, saturate at 3, clear against a coincident event
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_narrow", {n_corr_cnt, n_uncorr_cnt}, 0);
        check("clr_wide", {corr_cnt, uncorr_cnt}, 0);

        in_data = 32'h0000_0001;
        in_chk  = 7'h00;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("sat_narrow_corr_cnt", n_corr_cnt, 3);
        check("sat_wide_corr_cnt", corr_cnt, 5);

        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("clr_coincident_valid", {out_valid, out_corr}, 2'b11);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_coincident_narrow", n_corr_cnt, 0);
        check("clr_coincident_wide", corr_cnt, 0);

        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("count_after_clr", n_corr_cnt, 1);

        // Reset with two words in flight
        out_ready = 1'b0;
        in_data   = 32'h0000_0003;
        in_valid  = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        check("inflight_valid", out_valid, 1);
        check("inflight_s1_full", in_ready, 0);
        rst = 1'b1;
        tick();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_syndrome", out_syndrome, 0);
        check("midrst_flags", {out_corr, out_uncorr}, 0);
        check("midrst_counters", {corr_cnt, uncorr_cnt, n_corr_cnt, n_uncorr_cnt}, 0);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        check("postmid_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("no_stale_%0d", i), out_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
